// File: rtl/home_rr_arbiter.sv
// Round-robin home-automation arbiter.
// Arbitrates N_SENS masked binary sensors plus heater (cold) and cooler (hot)
// requests derived from a hysteretic temperature compare. One actuator is
// driven at a time, and each grant is held for at most MAX_HOLD cycles.
// All state changes on the falling edge of Clk.
module home_rr_arbiter #(
    parameter int N_SENS   = 4,
    parameter int TW       = 7,
    parameter int T_LOW    = 50,
    parameter int T_HIGH   = 70,
    parameter int HYST     = 2,
    parameter int MAX_HOLD = 4,
    localparam int NCH     = N_SENS + 2,
    localparam int DW      = $clog2(NCH + 1)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic [N_SENS-1:0] Sens,
    input  logic [N_SENS-1:0] SMask,
    input  logic [TW-1:0]     ST,
    output logic [NCH-1:0]    Act,
    output logic [DW-1:0]     display,
    output logic              busy
);
    localparam int IW = $clog2(NCH);
    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [TW-1:0] C_SET = TW'(T_LOW);
    localparam logic [TW-1:0] C_CLR = TW'(T_LOW + HYST);
    localparam logic [TW-1:0] H_SET = TW'(T_HIGH);
    localparam logic [TW-1:0] H_CLR = TW'(T_HIGH - HYST);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              r_state;
    logic [N_SENS-1:0]   r_sens;
    logic                r_cold;
    logic                r_hot;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_g;
    logic [HW-1:0]       r_hold;

    logic [NCH-1:0]      w_req;
    logic [IW-1:0]       w_nxt;
    logic [IW:0]         w_pf;
    logic [IW:0]         w_nf;

    // First requester at or after start, wrapping at NCH; MSB flags found.
    function automatic logic [IW:0] find_req(input logic [NCH-1:0] req,
                                             input logic [IW-1:0]  start);
        logic [IW:0] res;
        int          j;
        res = '0;
        // Scan farthest-first so the nearest hit is the one that sticks.
        for (int k = NCH - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= NCH) j = j - NCH;
            if (req[IW'(j)]) res = {1'b1, IW'(j)};
        end
        return res;
    endfunction

    assign w_req = {r_hot, r_cold, r_sens};
    assign w_nxt = (r_g == IW'(NCH - 1)) ? '0 : r_g + 1'b1;
    assign w_pf  = find_req(w_req, r_ptr);
    assign w_nf  = find_req(w_req, w_nxt);

    // Request stage: masked sensors and hysteretic cold/hot flags.
    always_ff @(negedge Clk) begin
        if (!Rst) begin
            r_sens <= '0;
            r_cold <= 1'b0;
            r_hot  <= 1'b0;
        end else begin
            r_sens <= Sens & ~SMask;
            if (ST < C_SET)       r_cold <= 1'b1;
            else if (ST >= C_CLR) r_cold <= 1'b0;
            if (ST > H_SET)       r_hot  <= 1'b1;
            else if (ST <= H_CLR) r_hot  <= 1'b0;
        end
    end

    // Grant FSM with registered outputs; ptr survives an enable drop.
    always_ff @(negedge Clk) begin
        if (!Rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_g     <= '0;
            r_hold  <= '0;
            Act     <= '0;
            display <= '0;
            busy    <= 1'b0;
        end else if (!En) begin
            r_state <= IDLE;
            r_hold  <= '0;
            Act     <= '0;
            display <= '0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pf[IW]) begin
                        r_state <= GRANT;
                        r_g     <= w_pf[IW-1:0];
                        r_hold  <= '0;
                        Act     <= NCH'(1) << w_pf[IW-1:0];
                        display <= DW'(w_pf[IW-1:0]) + DW'(1);
                        busy    <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!w_req[r_g] || r_hold == HW'(MAX_HOLD - 1)) begin
                        // Release or expiry: move past the winner, regrant with no gap.
                        r_ptr <= w_nxt;
                        if (w_nf[IW]) begin
                            r_g     <= w_nf[IW-1:0];
                            r_hold  <= '0;
                            Act     <= NCH'(1) << w_nf[IW-1:0];
                            display <= DW'(w_nf[IW-1:0]) + DW'(1);
                        end else begin
                            r_state <= IDLE;
                            r_hold  <= '0;
                            Act     <= '0;
                            display <= '0;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_home_rr_arbiter.sv
// Directed + randomized bench for home_rr_arbiter against a behavioural model.
// Inputs change and outputs are sampled on the rising edge; the DUT and the
// model both update on the falling edge.
module tb_home_rr_arbiter;
    localparam int NS  = 4;
    localparam int NCH = 6;
    localparam int MH  = 4;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          En = 1'b1;
    logic [NS-1:0] Sens = '0;
    logic [NS-1:0] SMask = '0;
    logic [6:0]    ST = 7'd60;
    logic [NCH-1:0] Act;
    logic [2:0]    display;
    logic          busy;

    int checks = 0;
    int errors = 0;

    home_rr_arbiter dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Sens(Sens), .SMask(SMask), .ST(ST),
        .Act(Act), .display(display), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Behavioural model: integer channel numbers, -1 meaning "nothing granted".
    int m_req[NCH];
    int m_cold = 0, m_hot = 0;
    int m_g = -1, m_ptr = 0, m_hold = 0;
    int m_both = 0;

    function automatic int mfind(int s);
        for (int k = 0; k < NCH; k++)
            if (m_req[(s + k) % NCH] != 0) return (s + k) % NCH;
        return -1;
    endfunction

    always @(negedge Clk) begin
        int t;
        if (!Rst) begin
            for (int i = 0; i < NCH; i++) m_req[i] = 0;
            m_cold = 0; m_hot = 0; m_g = -1; m_ptr = 0; m_hold = 0;
        end else begin
            if (!En) begin
                m_g = -1; m_hold = 0;
            end else if (m_g < 0) begin
                m_g = mfind(m_ptr); m_hold = 0;
            end else if (m_req[m_g] == 0 || m_hold == MH - 1) begin
                m_ptr = (m_g + 1) % NCH;
                m_g = mfind(m_ptr); m_hold = 0;
            end else begin
                m_hold++;
            end
            for (int i = 0; i < NS; i++) m_req[i] = (Sens[i] && !SMask[i]) ? 1 : 0;
            t = int'(ST);
            if (t < 50) m_cold = 1; else if (t >= 52) m_cold = 0;
            if (t > 70) m_hot = 1;  else if (t <= 68) m_hot = 0;
            if (m_cold != 0 && m_hot != 0) m_both = 1;
            m_req[NS] = m_cold; m_req[NS + 1] = m_hot;
        end
    end

    task automatic chk_model(input string tag);
        logic [NCH-1:0] ea;
        logic [2:0]     ed;
        logic           eb;
        ea = (m_g < 0) ? '0 : NCH'(1) << m_g;
        ed = (m_g < 0) ? 3'd0 : 3'(m_g + 1);
        eb = (m_g >= 0);
        checks++;
        assert (Act === ea && display === ed && busy === eb) else begin
            errors++;
            $error("FAIL %s act=%b disp=%0d busy=%b exp act=%b disp=%0d busy=%b",
                   tag, Act, display, busy, ea, ed, eb);
        end
        checks++;
        assert ($onehot0(Act)) else begin
            errors++;
            $error("FAIL %s_onehot act=%b exp onehot0", tag, Act);
        end
    endtask

    task automatic chk_const(input string tag, input logic [NCH-1:0] ea, input logic [2:0] ed);
        checks++;
        assert (Act === ea && display === ed) else begin
            errors++;
            $error("FAIL %s act=%b disp=%0d exp act=%b disp=%0d", tag, Act, display, ea, ed);
        end
    endtask

    // One falling edge, then sample at the following rising edge.
    task automatic step(input string tag);
        @(posedge Clk);
        chk_model(tag);
    endtask

    task automatic do_reset();
        Rst = 1'b0; En = 1'b1; Sens = '0; SMask = '0; ST = 7'd60;
        step("rst_a"); step("rst_b");
        Rst = 1'b1;
    endtask

    initial begin
        // 1. Reset with all sensors asserted
        Sens = 4'hF;
        step("t1_rst0"); step("t1_rst1");
        chk_const("t1_rst", 6'b0, 3'd0);
        Rst = 1'b1;
        step("t1_rel1"); chk_const("t1_rel1", 6'b0, 3'd0);
        step("t1_rel2"); chk_const("t1_first", 6'b000001, 3'd1);

        // 2. Single requester held across several expiries
        do_reset();
        Sens = 4'b0100;
        step("t2_a"); step("t2_b");
        for (int i = 0; i < 12; i++) begin
            step("t2_hold"); chk_const("t2_hold", 6'b000100, 3'd3);
        end
        Sens = 4'b0000;
        step("t2_drop1"); chk_const("t2_drop1", 6'b000100, 3'd3);
        step("t2_drop2"); chk_const("t2_drop2", 6'b0, 3'd0);

        // 3. Round robin between channels 0 and 3
        do_reset();
        Sens = 4'b1001;
        step("t3_req");
        for (int i = 0; i < 4; i++) begin step("t3_c0"); chk_const("t3_c0", 6'b000001, 3'd1); end
        for (int i = 0; i < 4; i++) begin step("t3_c3"); chk_const("t3_c3", 6'b001000, 3'd4); end
        step("t3_c0b"); chk_const("t3_c0b", 6'b000001, 3'd1);
        Sens = 4'b1000;
        step("t3_d1"); chk_const("t3_d1", 6'b000001, 3'd1);
        step("t3_d2"); chk_const("t3_sw3", 6'b001000, 3'd4);

        // 4. Hysteresis on both thresholds
        do_reset();
        ST = 7'd49; step("t4_a"); step("t4_b"); chk_const("t4_cold", 6'b010000, 3'd5);
        ST = 7'd51; step("t4_c"); step("t4_d"); chk_const("t4_51", 6'b010000, 3'd5);
        ST = 7'd52; step("t4_e"); step("t4_f"); chk_const("t4_52", 6'b0, 3'd0);
        ST = 7'd71; step("t4_g"); step("t4_h"); chk_const("t4_hot", 6'b100000, 3'd6);
        ST = 7'd69; step("t4_i"); step("t4_j"); chk_const("t4_69", 6'b100000, 3'd6);
        ST = 7'd68; step("t4_k"); step("t4_l"); chk_const("t4_68", 6'b0, 3'd0);

        // 5. Cold-to-hot jump hands over without a gap
        do_reset();
        ST = 7'd40; step("t5_a"); step("t5_b"); chk_const("t5_cold", 6'b010000, 3'd5);
        ST = 7'd80; step("t5_c"); chk_const("t5_c", 6'b010000, 3'd5);
        step("t5_d"); chk_const("t5_hot", 6'b100000, 3'd6);

        // 6. Masking, enable and reset mid-grant
        do_reset();
        Sens = 4'b0010; SMask = 4'b0010;
        for (int i = 0; i < 3; i++) begin step("t6_mask"); chk_const("t6_mask", 6'b0, 3'd0); end
        SMask = 4'b0000; Sens = 4'b1000;
        step("t6_a"); step("t6_b"); chk_const("t6_g3", 6'b001000, 3'd4);
        En = 1'b0; Sens = 4'b1001;
        step("t6_en0"); chk_const("t6_en0", 6'b0, 3'd0);
        step("t6_en0b");
        En = 1'b1;
        step("t6_en1"); chk_const("t6_en1", 6'b000001, 3'd1);
        Rst = 1'b0;
        step("t6_rst"); chk_const("t6_rst", 6'b0, 3'd0);
        checks++;
        assert (busy === 1'b0) else begin
            errors++; $error("FAIL t6_rst_busy busy=%b exp 0", busy);
        end
        Rst = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) Sens = NS'($urandom);
            SMask = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
            if ($urandom_range(0, 3) == 0) ST = 7'($urandom_range(35, 85));
            En  = ($urandom_range(0, 15) != 0);
            Rst = ($urandom_range(0, 63) != 0);
            step("rand");
        end

        checks++;
        assert (m_both == 0) else begin
            errors++; $error("FAIL model_cold_hot both=%0d exp 0", m_both);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
